// File: rtl/duty_ramp_pkg.sv
// duty_ramp_pkg: state encoding, shared constants and the level-to-duty map.
// Build option: define DUTY_RAMP_GAMMA_EN to replace the identity map with
// the quadratic gamma curve (L*(L+1))>>8.
package duty_ramp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_e;

  localparam logic [7:0] PERIOD_MAX = 8'hFF;
  localparam logic [7:0] LEVEL_MAX  = 8'd255;

  // Brightness level to PWM duty. The gamma variant squares the level so a
  // linear ramp looks perceptually linear; 255*256 still fits in 16 bits.
  function automatic logic [7:0] map_level(input logic [7:0] level);
`ifdef DUTY_RAMP_GAMMA_EN
    logic [15:0] prod;
    prod = {8'd0, level} * ({8'd0, level} + 16'd1);
    return prod[15:8];
`else
    return level;
`endif
  endfunction

endpackage

// File: rtl/duty_ramp_period_tick.sv
// period_tick: free-running 8-bit PWM period counter plus a prescaler that
// turns every (presc+1)-th period boundary into a one-cycle step tick.
module period_tick
  import duty_ramp_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               wrap,
  output logic               tick
);

  logic [7:0]         pcnt_reg;
  logic [PRESC_W-1:0] qcnt_reg;

  assign wrap = (pcnt_reg == PERIOD_MAX);
  assign tick = run && wrap && (qcnt_reg == presc);

  // Period counter never stops so it stays in lockstep with pwm8's counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_reg <= '0;
    else        pcnt_reg <= pcnt_reg + 8'd1;
  end

  // Prescaler counts period boundaries while running, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_reg <= '0;
    end else if (!run) begin
      qcnt_reg <= '0;
    end else if (wrap) begin
      if (qcnt_reg == presc) qcnt_reg <= '0;
      else                   qcnt_reg <= qcnt_reg + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// duty_ramp: breathing-envelope generator (rise, hold high, fall, hold low,
// then stop or loop) feeding an 8-bit duty cycle to pwm8. The duty register
// only changes at PWM period boundaries so every PWM period is whole.
// Build option: DUTY_RAMP_GAMMA_EN selects the gamma duty map (see package).
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               loop,
  input  logic [PRESC_W-1:0] presc,
  input  logic [7:0]         step,
  input  logic [7:0]         hold_hi,
  input  logic [7:0]         hold_lo,
  output logic [7:0]         duty_o,
  output logic [2:0]         phase_o,
  output logic               done_o
);

  state_e     state_reg, state_next;
  logic [7:0] level_reg, level_next;
  logic [7:0] hcnt_reg, hcnt_next;
  logic       done_reg, done_next;
  logic [7:0] duty_reg;
  logic [7:0] step_eff;
  logic [8:0] sum9;
  logic       run;
  logic       wrap;
  logic       tick;

  // Prescaler only runs while an envelope is active and enabled.
  assign run = en && (state_reg != IDLE);

  period_tick #(.PRESC_W(PRESC_W)) u_period_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .presc (presc),
    .wrap  (wrap),
    .tick  (tick)
  );

  // A zero step would stall the ramp forever, so it behaves as 1.
  assign step_eff = (step == 8'd0) ? 8'd1 : step;
  assign sum9     = {1'b0, level_reg} + {1'b0, step_eff};

  // Envelope sequencing: level and dwell counter advance only on step ticks.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    hcnt_next  = hcnt_reg;
    done_next  = 1'b0;
    if (!en) begin
      state_next = IDLE;
      level_next = 8'd0;
      hcnt_next  = 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = RISE;
          level_next = 8'd0;
          hcnt_next  = 8'd0;
        end
        RISE: begin
          if (tick) begin
            if (sum9 >= {1'b0, LEVEL_MAX}) begin
              level_next = LEVEL_MAX;
              state_next = HOLD_HI;
              hcnt_next  = 8'd0;
            end else begin
              level_next = sum9[7:0];
            end
          end
        end
        HOLD_HI: begin
          if (tick) begin
            if (hcnt_reg >= hold_hi) state_next = FALL;
            else                     hcnt_next  = hcnt_reg + 8'd1;
          end
        end
        FALL: begin
          if (tick) begin
            if (level_reg <= step_eff) begin
              level_next = 8'd0;
              state_next = HOLD_LO;
              hcnt_next  = 8'd0;
            end else begin
              level_next = level_reg - step_eff;
            end
          end
        end
        HOLD_LO: begin
          if (tick) begin
            if (hcnt_reg >= hold_lo) begin
              if (loop) begin
                state_next = RISE;
              end else begin
                state_next = IDLE;
                done_next  = 1'b1;
              end
            end else begin
              hcnt_next = hcnt_reg + 8'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          level_next = 8'd0;
          hcnt_next  = 8'd0;
        end
      endcase
    end
  end

  // Envelope state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      level_reg <= 8'd0;
      hcnt_reg  <= 8'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      hcnt_reg  <= hcnt_next;
      done_reg  <= done_next;
    end
  end

  // Duty loads on the wrap edge so the new value starts a fresh PWM period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    duty_reg <= 8'd0;
    else if (wrap) duty_reg <= map_level(level_next);
  end

  assign duty_o  = duty_reg;
  assign phase_o = state_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed + randomized envelopes checked against a per-tick
// envelope list built from the documented ramp/hold rules.
module tb_duty_ramp;

  localparam int P_IDLE    = 0;
  localparam int P_RISE    = 1;
  localparam int P_HOLD_HI = 2;
  localparam int P_FALL    = 3;
  localparam int P_HOLD_LO = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       loop    = 1'b0;
  logic [7:0] presc   = 8'd0;
  logic [7:0] step    = 8'd0;
  logic [7:0] hold_hi = 8'd0;
  logic [7:0] hold_lo = 8'd0;
  logic [7:0] duty_o;
  logic [2:0] phase_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Envelope per step tick: level after the tick, phase after it, done flag.
  int q_duty[$];
  int q_phase[$];
  int q_done[$];

  duty_ramp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .loop    (loop),
    .presc   (presc),
    .step    (step),
    .hold_hi (hold_hi),
    .hold_lo (hold_lo),
    .duty_o  (duty_o),
    .phase_o (phase_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gmap(input int lv);
`ifdef DUTY_RAMP_GAMMA_EN
    return (lv * (lv + 1)) / 256;
`else
    return lv;
`endif
  endfunction

  function automatic void build_env(input int s, input int hh, input int hl, input int lp);
    int lv;
    int se;
    q_duty.delete();
    q_phase.delete();
    q_done.delete();
    se = (s == 0) ? 1 : s;
    lv = 0;
    do begin
      lv = (lv + se > 255) ? 255 : lv + se;
      q_duty.push_back(lv);
      q_phase.push_back((lv == 255) ? P_HOLD_HI : P_RISE);
      q_done.push_back(0);
    end while (lv != 255);
    for (int i = 0; i <= hh; i++) begin
      q_duty.push_back(255);
      q_phase.push_back((i == hh) ? P_FALL : P_HOLD_HI);
      q_done.push_back(0);
    end
    do begin
      lv = (lv > se) ? lv - se : 0;
      q_duty.push_back(lv);
      q_phase.push_back((lv == 0) ? P_HOLD_LO : P_FALL);
      q_done.push_back(0);
    end while (lv != 0);
    for (int i = 0; i <= hl; i++) begin
      q_duty.push_back(0);
      q_phase.push_back((i == hl) ? (lp != 0 ? P_RISE : P_IDLE) : P_HOLD_LO);
      q_done.push_back((i == hl && lp == 0) ? 1 : 0);
    end
  endfunction

  task automatic step_clk();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Period boundaries fall on every 256th clock after reset release.
  task automatic wait_wrap();
    do step_clk(); while (cyc % 256 != 0);
  endtask

  // Runs one envelope; sync=1 starts it from IDLE right after a period boundary.
  task automatic run_env(input int p, input int s, input int hh, input int hl,
                         input int lp, input int max_wraps, input bit sync);
    int  j, idx, n, exp_d, exp_p, exp_dn, dn_seen;
    bit  finished;
    presc   = p[7:0];
    step    = s[7:0];
    hold_hi = hh[7:0];
    hold_lo = hl[7:0];
    loop    = (lp != 0);
    if (sync) wait_wrap();
    en = 1'b1;
    build_env(s, hh, hl, lp);
    n = q_duty.size();
    finished = 1'b0;
    for (int w = 1; w <= max_wraps && !finished; w++) begin
      wait_wrap();
      j = w / (p + 1);
      if (j == 0) begin
        exp_d = 0; exp_p = P_RISE; exp_dn = 0;
      end else begin
        idx    = (j - 1) % n;
        exp_d  = gmap(q_duty[idx]);
        exp_p  = q_phase[idx];
        exp_dn = (w % (p + 1) == 0) ? q_done[idx] : 0;
      end
      $display("wrap p=%0d s=%0d hh=%0d hl=%0d lp=%0d w=%0d duty=%0d phase=%0d done=%0d",
               p, s, hh, hl, lp, w, duty_o, phase_o, done_o);
      check("duty", duty_o, exp_d);
      check("phase", phase_o, exp_p);
      check("done", done_o, exp_dn);
      if (exp_dn != 0) finished = 1'b1;
    end
    en = 1'b0;
    if (finished) begin
      step_clk();
      check("done_width", done_o, 0);
      check("idle_after_done", phase_o, P_IDLE);
    end else begin
      step_clk();
      dn_seen = done_o;
      check("en_drop_phase", phase_o, P_IDLE);
      while (cyc % 256 != 0) begin
        step_clk();
        dn_seen = dn_seen | done_o;
      end
      check("en_drop_duty", duty_o, 0);
      check("en_drop_done", dn_seen, 0);
    end
  endtask

  initial begin
    // Reset with en held high.
    presc = 8'd0; step = 8'd64; hold_hi = 8'd0; hold_lo = 8'd0; loop = 1'b0;
    en = 1'b1;
    #12;
    check("rst_duty", duty_o, 0);
    check("rst_phase", phase_o, P_IDLE);
    check("rst_done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // One-shot straight out of reset.
    run_env(0, 64, 0, 0, 0, 20, 1'b0);
    // Looping envelope wraps back into RISE at 64.
    run_env(0, 64, 0, 0, 1, 12, 1'b1);
    // Zero step behaves as 1, two periods per tick.
    run_env(1, 0, 0, 0, 0, 6, 1'b1);
    // Large step saturates at 255 rather than wrapping.
    run_env(0, 200, 1, 0, 0, 20, 1'b1);
    // Enable dropped while duty sits at 192 in RISE.
    run_env(0, 64, 0, 0, 0, 3, 1'b1);

    for (int r = 0; r < 3; r++) begin
      int rp, rs, rhh, rhl, rlp;
      rp  = int'($urandom_range(0, 1));
      rs  = int'($urandom_range(40, 255));
      rhh = int'($urandom_range(0, 2));
      rhl = int'($urandom_range(0, 2));
      rlp = int'($urandom_range(0, 1));
      run_env(rp, rs, rhh, rhl, rlp, 40, 1'b1);
    end

    // Asynchronous reset in the middle of a ramp.
    presc = 8'd0; step = 8'd64; hold_hi = 8'd0; hold_lo = 8'd0; loop = 1'b0;
    wait_wrap();
    en = 1'b1;
    wait_wrap();
    wait_wrap();
    check("pre_reset_duty", duty_o, gmap(128));
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset duty=%0d phase=%0d done=%0d", duty_o, phase_o, done_o);
    check("async_rst_duty", duty_o, 0);
    check("async_rst_phase", phase_o, P_IDLE);
    check("async_rst_done", done_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
